// File: rtl/hit_detector.sv
// hit_detector: bunny/obstacle collision detector with post-hit grace period; optional HIT_BLINK_EN adds a tick-toggled blink register.
module hit_detector #(
  parameter int GRACE_TICKS = 8,
  parameter int NUM_OBS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   game_en,
  input  logic                   die,
  input  logic [3:0]             bunny_col,
  input  logic [1:0]             bunny_row,
  input  logic [NUM_OBS-1:0]     obs_valid,
  input  logic [4*NUM_OBS-1:0]   obs_col,
  input  logic [2*NUM_OBS-1:0]   obs_row,
  output logic                   hit,
  output logic                   invuln,
  output logic                   blink,
  output logic [7:0]             hit_count
);
  localparam logic [1:0] ARMED = 2'd0;
  localparam logic [1:0] GRACE = 2'd1;
  localparam logic [1:0] DEAD  = 2'd2;
  logic [1:0] state_q, state_d;
  logic [3:0] grace_cnt_q, grace_cnt_d;
  logic       hit_q, hit_d;
  logic       invuln_q, invuln_d;
  logic [7:0] hit_count_q, hit_count_d;
  logic       coll;
  // any valid slot sharing the bunny's cell is a collision
  always_comb begin
    coll = 1'b0;
    for (int i = 0; i < NUM_OBS; i++)
      coll = coll | (obs_valid[i] && obs_col[4*i+:4] == bunny_col && obs_row[2*i+:2] == bunny_row);
  end
  // next state: die beats collision, collisions only count when armed and running
  always_comb begin
    state_d     = state_q;
    grace_cnt_d = grace_cnt_q;
    hit_d       = 1'b0;
    if (die) begin
      state_d     = DEAD;
      grace_cnt_d = 4'd0;
    end else if (state_q == ARMED && game_en && coll) begin
      state_d     = GRACE;
      grace_cnt_d = 4'(GRACE_TICKS);
      hit_d       = 1'b1;
    end else if (state_q == GRACE && game_en && tick) begin
      grace_cnt_d = grace_cnt_q - {3'd0, grace_cnt_q != 4'd0};
      state_d     = grace_cnt_q <= 4'd1 ? ARMED : GRACE;
    end
    hit_count_d = hit_count_q + {7'd0, hit_d && hit_count_q != 8'hff};
    invuln_d    = state_d == GRACE;
  end
  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARMED;
      grace_cnt_q <= 4'd0;
      hit_q       <= 1'b0;
      invuln_q    <= 1'b0;
      hit_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      grace_cnt_q <= grace_cnt_d;
      hit_q       <= hit_d;
      invuln_q    <= invuln_d;
      hit_count_q <= hit_count_d;
    end
  end
`ifdef HIT_BLINK_EN
  logic blink_q, blink_d;
  // blink starts at 0 on entry to grace and flips on each running tick while staying in grace
  always_comb blink_d = (state_d == GRACE && state_q == GRACE) ? blink_q ^ (tick && game_en) : 1'b0;
  // blink register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_q <= 1'b0;
    else     blink_q <= blink_d;
  end
  assign blink = blink_q;
`else
  assign blink = invuln_q;
`endif
  assign hit       = hit_q;
  assign invuln    = invuln_q;
  assign hit_count = hit_count_q;
endmodule

// File: tb/tb_hit_detector.sv
// tb_hit_detector: directed self-checking bench for hit_detector
module tb_hit_detector;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        game_en = 1'b0;
  logic        die = 1'b0;
  logic [3:0]  bunny_col = 4'd3;
  logic [1:0]  bunny_row = 2'd1;
  logic [3:0]  obs_valid = 4'b0000;
  logic [15:0] obs_col = 16'h0333;
  logic [7:0]  obs_row = 8'h19;
  logic        hit, invuln, blink;
  logic [7:0]  hit_count;
  int checks = 0;
  int errors = 0;
  int hits = 0;
  logic bl = 1'b0;

  hit_detector #(.GRACE_TICKS(8), .NUM_OBS(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .game_en(game_en), .die(die),
    .bunny_col(bunny_col), .bunny_row(bunny_row), .obs_valid(obs_valid),
    .obs_col(obs_col), .obs_row(obs_row),
    .hit(hit), .invuln(invuln), .blink(blink), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic h, input logic inv, input int cnt, input logic b);
    logic eb;
`ifdef HIT_BLINK_EN
    eb = b;
`else
    eb = inv;
`endif
    check({tag, "_hit"}, 32'(hit), 32'(h));
    check({tag, "_invuln"}, 32'(invuln), 32'(inv));
    check({tag, "_count"}, 32'(hit_count), 32'(cnt));
    check({tag, "_blink"}, 32'(blink), 32'(eb));
  endtask

  initial begin
    step(2);
    expect_out("rst", 0, 0, 0, 0);
    rst = 1'b0;
    game_en = 1'b1;
    obs_valid = 4'b1010;
    step(3);
    expect_out("near_miss", 0, 0, 0, 0);
    obs_valid = 4'b0100;
    game_en = 1'b0;
    step(3);
    expect_out("paused_armed", 0, 0, 0, 0);
    game_en = 1'b1;
    step();
    expect_out("hit1", 1, 1, 1, 0);
    step();
    expect_out("hit1_end", 0, 1, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      pulse_tick();
      bl = ~bl;
      expect_out("grace_a", 0, 1, 1, bl);
    end
    game_en = 1'b0;
    repeat (20) pulse_tick();
    expect_out("grace_paused", 0, 1, 1, bl);
    game_en = 1'b1;
    for (int i = 4; i <= 7; i++) begin
      pulse_tick();
      bl = ~bl;
      expect_out("grace_b", 0, 1, 1, bl);
    end
    pulse_tick();
    expect_out("grace_exit", 0, 0, 1, 0);
    step();
    expect_out("hit2", 1, 1, 2, 0);
    step();
    expect_out("hit2_end", 0, 1, 2, 0);
    obs_valid = 4'b0000;
    #2 rst = 1'b1;
    #1 expect_out("async_rst", 0, 0, 0, 0);
    step();
    rst = 1'b0;
    step(2);
    expect_out("post_rst", 0, 0, 0, 0);
    obs_valid = 4'b0100;
    die = 1'b1;
    step();
    expect_out("die_coll", 0, 0, 0, 0);
    die = 1'b0;
    step(3);
    expect_out("dead", 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      obs_valid = 4'b0100;
      step();
      if (hit) hits++;
      if (n == 255) check("count_255", 32'(hit_count), 255);
      obs_valid = 4'b0000;
      repeat (8) pulse_tick();
    end
    check("sat_count", 32'(hit_count), 255);
    check("sat_hits", 32'(hits), 300);
    obs_valid = 4'b0100;
    step();
    expect_out("sat_hit", 1, 1, 255, 0);
    obs_valid = 4'b0000;
    #2 rst = 1'b1;
    #1 expect_out("rst_grace", 0, 0, 0, 0);
    step();
    rst = 1'b0;
    obs_valid = 4'b0100;
    step();
    expect_out("hit3", 1, 1, 1, 0);
    die = 1'b1;
    step();
    expect_out("die_grace", 0, 0, 1, 0);
    die = 1'b0;
    step(3);
    expect_out("dead2", 0, 0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
